irq_gate: RTL and testbench

- Interrupt-side counterpart to the secure-region IRQ monitor. It sits between the peripheral IRQ lines and the CPU interrupt inputs.
- While the PC is inside secure memory (SMEM), requests are latched as pending and withheld. They are released to the CPU only after the PC has stayed outside SMEM for a guard interval.
- Its summary output drives the monitor's irq input. A correct gate therefore never triggers the monitor's kill path.

---
 rtl/irq_gate_pkg.sv | 26 ++
 rtl/irq_pend_reg.sv | 26 ++
 rtl/irq_gate.sv | 109 ++++++++++
 tb/tb_irq_gate.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_gate_pkg.sv
// Shared types and region helper for the secure-region IRQ gate.
// The region test is shared with the monitor so both agree on bounds.
package irq_gate_pkg;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_CLOSED = 2'd1,
    ST_GUARD  = 2'd2
  } gate_state_t;

  localparam int unsigned GUARD_W = 4;
  localparam int unsigned TMR_W   = 16;
  localparam int unsigned DCNT_W  = 8;

  // Last word address is inclusive: base + size - 2.
  function automatic logic smem_contains(
    input logic [15:0] pc,
    input logic [15:0] base,
    input logic [15:0] size
  );
    logic [15:0] last;
    last = base + size - 16'd2;
    return (pc >= base) && (pc <= last);
  endfunction

endpackage

// File: rtl/irq_pend_reg.sv
// Per-line pending latch with CPU ack and rising-edge summary.
// Set wins over ack when the source is still asserting.
module irq_pend_reg
  import irq_gate_pkg::*;
#(
  parameter int unsigned NIRQ = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] irq_ack_cpu,
  output logic [NIRQ-1:0] pend,
  output logic            rise
);

  logic [NIRQ-1:0] pend_nx;

  assign pend_nx = (pend & ~irq_ack_cpu) | irq_in;
  assign rise    = |(pend_nx & ~pend);

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_nx;
  end

endmodule

// File: rtl/irq_gate.sv
// Withholds peripheral IRQs while the PC is in secure memory and
// releases them after a guard interval outside it.
module irq_gate
  import irq_gate_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE  = 16'hE000,
  parameter logic [15:0] SMEM_SIZE  = 16'h1000,
  parameter int unsigned NIRQ       = 14,
  parameter int unsigned EXIT_GUARD = 2,
  parameter logic [15:0] DEFER_MAX  = 16'd4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     pc,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] irq_ack_cpu,
  output logic [NIRQ-1:0] irq_out,
  output logic [NIRQ-1:0] irq_ack_src,
  output logic            irq,
  output logic [7:0]      deferred_cnt,
  output logic            defer_ovf
);

  localparam logic [GUARD_W-1:0] GUARD_END = GUARD_W'(EXIT_GUARD);

  gate_state_t        state;
  logic [GUARD_W-1:0] guard_cnt;
  logic [GUARD_W-1:0] guard_nx;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nx;
  logic [NIRQ-1:0]    pend;
  logic               rise;
  logic               in_smem;
  logic               masking;
  logic               open_out;

  irq_pend_reg #(.NIRQ(NIRQ)) u_pend (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .irq_ack_cpu (irq_ack_cpu),
    .pend        (pend),
    .rise        (rise)
  );

  assign in_smem  = smem_contains(pc, SMEM_BASE, SMEM_SIZE);
  assign open_out = (state == ST_OPEN) && !in_smem;
  assign masking  = !open_out;
  assign guard_nx = guard_cnt + 1'b1;

  assign irq_out     = pend & {NIRQ{open_out}};
  assign irq         = |irq_out;
  assign irq_ack_src = irq_ack_cpu & pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_OPEN;
      guard_cnt <= '0;
    end else begin
      unique case (state)
        ST_OPEN: begin
          if (in_smem) state <= ST_CLOSED;
        end
        ST_CLOSED: begin
          if (!in_smem) begin
            state     <= ST_GUARD;
            guard_cnt <= GUARD_W'(1);
          end
        end
        ST_GUARD: begin
          if (in_smem) begin
            state     <= ST_CLOSED;
            guard_cnt <= '0;
          end else if (guard_nx >= GUARD_END) begin
            state     <= ST_OPEN;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_nx;
          end
        end
        default: begin
          state     <= ST_OPEN;
          guard_cnt <= '0;
        end
      endcase
    end
  end

  // Timer only runs while something is actually being held back.
  always_comb begin
    timer_nx = '0;
    if (masking && (pend != '0))
      timer_nx = (timer == '1) ? timer : timer + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer        <= '0;
      defer_ovf    <= 1'b0;
      deferred_cnt <= '0;
    end else begin
      timer <= timer_nx;
      if (timer_nx >= DEFER_MAX) defer_ovf <= 1'b1;
      if (masking && rise && (deferred_cnt != 8'hFF))
        deferred_cnt <= deferred_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_irq_gate.sv
// Directed bench for irq_gate.
// Each task drives one scenario and checks its own results.
module tb_irq_gate;
  import irq_gate_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [13:0] irq_in;
  logic [13:0] irq_ack_cpu;
  logic [13:0] irq_out;
  logic [13:0] irq_ack_src;
  logic        irq;
  logic [7:0]  deferred_cnt;
  logic        defer_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  irq_gate dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .irq_in       (irq_in),
    .irq_ack_cpu  (irq_ack_cpu),
    .irq_out      (irq_out),
    .irq_ack_src  (irq_ack_src),
    .irq          (irq),
    .deferred_cnt (deferred_cnt),
    .defer_ovf    (defer_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety property: never an IRQ while PC is inside secure memory.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_chk++;
      if (irq === 1'b1 && pc >= 16'hE000 && pc <= 16'hEFFE) begin
        n_fail++;
        $display("FAIL irq_in_smem pc=%h irq=%b required 0", pc, irq);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    pc = 16'h0000;
    irq_in = '0;
    irq_ack_cpu = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if (irq_out !== 14'h0) begin
      n_fail++; $display("FAIL rst_irq_out got %h want 0", irq_out);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL rst_irq got %b want 0", irq);
    end
    n_chk++;
    if (deferred_cnt !== 8'h0 || defer_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cnt got %h/%b want 0/0", deferred_cnt, defer_ovf);
    end
  endtask

  task automatic test_basic();
    pc = 16'h4000;
    irq_in = 14'h0008;
    #1;
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency got %b want 0", irq);
    end
    tick();
    irq_in = '0;
    #1;
    n_chk++;
    if (irq_out !== 14'h0008 || irq !== 1'b1) begin
      n_fail++; $display("FAIL basic_out got %h/%b want 0008/1", irq_out, irq);
    end
    irq_ack_cpu = 14'h0008;
    #1;
    n_chk++;
    if (irq_ack_src !== 14'h0008) begin
      n_fail++; $display("FAIL basic_ack_src got %h want 0008", irq_ack_src);
    end
    tick();
    irq_ack_cpu = 14'h0010;
    #1;
    n_chk++;
    if (irq_out !== 14'h0) begin
      n_fail++; $display("FAIL basic_cleared got %h want 0", irq_out);
    end
    n_chk++;
    if (irq_ack_src !== 14'h0) begin
      n_fail++; $display("FAIL ack_drop got %h want 0", irq_ack_src);
    end
    tick();
    irq_ack_cpu = '0;
  endtask

  task automatic test_smem_entry();
    pc = 16'hDFFE;
    irq_in = 14'h0020;
    tick();
    irq_in = '0;
    #1;
    n_chk++;
    if (irq_out !== 14'h0020) begin
      n_fail++; $display("FAIL below_base got %h want 0020", irq_out);
    end
    pc = 16'hE000;
    #1;
    n_chk++;
    if (irq_out !== 14'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL entry_mask got %h/%b want 0/0", irq_out, irq);
    end
    tick();
    n_chk++;
    if (dut.state !== ST_CLOSED) begin
      n_fail++; $display("FAIL entry_state got %0d want CLOSED", dut.state);
    end
    pc = 16'hEFFE;
    tick();
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL last_addr got %b want 0", irq);
    end
    n_chk++;
    if (deferred_cnt !== 8'd0) begin
      n_fail++; $display("FAIL open_rise_cnt got %0d want 0", deferred_cnt);
    end
  endtask

  task automatic test_deferred_release();
    irq_ack_cpu = 14'h0020;
    #1;
    n_chk++;
    if (irq_ack_src !== 14'h0020) begin
      n_fail++; $display("FAIL masked_ack got %h want 0020", irq_ack_src);
    end
    tick();
    irq_ack_cpu = '0;
    irq_in = 14'h0001;
    tick();
    irq_in = '0;
    tick();
    irq_in = 14'h0080;
    tick();
    irq_in = '0;
    #1;
    n_chk++;
    if (deferred_cnt !== 8'd2 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL defer_cnt got %0d/%b want 2/0", deferred_cnt, irq);
    end
    pc = 16'hF000;
    #1;
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL guard_c0 got %b want 0", irq);
    end
    tick();
    n_chk++;
    if (irq !== 1'b0 || dut.state !== ST_GUARD) begin
      n_fail++; $display("FAIL guard_c1 got %b/%0d want 0/GUARD", irq, dut.state);
    end
    tick();
    n_chk++;
    if (irq_out !== 14'h0081) begin
      n_fail++; $display("FAIL release got %h want 0081", irq_out);
    end
    irq_ack_cpu = 14'h0001;
    tick();
    irq_ack_cpu = 14'h0080;
    tick();
    irq_ack_cpu = '0;
    #1;
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL release_ack got %b want 0", irq);
    end
  endtask

  task automatic test_guard_bounce();
    pc = 16'hE100;
    irq_in = 14'h0004;
    tick();
    irq_in = '0;
    tick();
    pc = 16'h4000;
    tick();
    pc = 16'hE100;
    #1;
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL bounce_back got %b want 0", irq);
    end
    tick();
    n_chk++;
    if (dut.state !== ST_CLOSED) begin
      n_fail++; $display("FAIL bounce_state got %0d want CLOSED", dut.state);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (irq !== 1'b0) begin
        n_fail++; $display("FAIL bounce_hold[%0d] got %b want 0", i, irq);
      end
    end
    pc = 16'h4000;
    tick();
    tick();
    n_chk++;
    if (irq_out !== 14'h0004) begin
      n_fail++; $display("FAIL bounce_release got %h want 0004", irq_out);
    end
    irq_ack_cpu = 14'h0004;
    tick();
    irq_ack_cpu = '0;
  endtask

  task automatic test_defer_ovf();
    pc = 16'hE100;
    irq_in = 14'h0002;
    tick();
    irq_in = '0;
    repeat (4095) tick();
    n_chk++;
    if (defer_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_early got %b want 0", defer_ovf);
    end
    tick();
    n_chk++;
    if (defer_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got %b want 1", defer_ovf);
    end
    pc = 16'h4000;
    repeat (3) tick();
    n_chk++;
    if (defer_ovf !== 1'b1 || irq_out !== 14'h0002) begin
      n_fail++;
      $display("FAIL ovf_sticky got %b/%h want 1/0002", defer_ovf, irq_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if (defer_ovf !== 1'b0 || deferred_cnt !== 8'd0 || irq_out !== 14'h0) begin
      n_fail++;
      $display("FAIL ovf_reset got %b/%0d/%h want 0/0/0",
               defer_ovf, deferred_cnt, irq_out);
    end
  endtask

  task automatic defer_events(input int n);
    for (int i = 0; i < n; i++) begin
      irq_in = 14'h0001;
      irq_ack_cpu = '0;
      tick();
      irq_in = '0;
      irq_ack_cpu = 14'h0001;
      tick();
    end
    irq_ack_cpu = '0;
  endtask

  task automatic test_saturation();
    pc = 16'hE100;
    defer_events(254);
    n_chk++;
    if (deferred_cnt !== 8'hFE) begin
      n_fail++; $display("FAIL sat_254 got %h want FE", deferred_cnt);
    end
    defer_events(1);
    n_chk++;
    if (deferred_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL sat_255 got %h want FF", deferred_cnt);
    end
    defer_events(45);
    n_chk++;
    if (deferred_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL sat_300 got %h want FF", deferred_cnt);
    end
  endtask

  task automatic test_reset_in_guard();
    irq_in = 14'h0010;
    tick();
    irq_in = '0;
    pc = 16'h4000;
    tick();
    n_chk++;
    if (dut.state !== ST_GUARD || irq !== 1'b0) begin
      n_fail++; $display("FAIL pre_rst got %0d/%b want GUARD/0", dut.state, irq);
    end
    reset = 1'b1;
    tick();
    n_chk++;
    if (dut.state !== ST_OPEN || irq_out !== 14'h0) begin
      n_fail++;
      $display("FAIL guard_rst got %0d/%h want OPEN/0", dut.state, irq_out);
    end
    reset = 1'b0;
    tick();
    n_chk++;
    if (irq_out !== 14'h0) begin
      n_fail++; $display("FAIL post_rst got %h want 0", irq_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_smem_entry();
    test_deferred_release();
    test_guard_bounce();
    test_defer_ovf();
    test_saturation();
    test_reset_in_guard();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
